// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if
//   Handshake bundle for the immediate generator stage.
//   Upstream side : in_valid, in_ready, instr, imm_sel, in_tag
//   Downstream side: out_valid, out_ready, imm, illegal, out_tag
//   modport slave  - the stage itself
//   modport master - whoever feeds instructions and consumes results
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, instr, imm_sel, in_tag, out_ready,
    output in_ready, out_valid, imm, illegal, out_tag
  );

  modport master (
    output in_valid, instr, imm_sel, in_tag, out_ready,
    input  in_ready, out_valid, imm, illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Pipelined immediate generator sitting between fetch and execute.
//   Extracts the I/S/B/J/U immediate of a 32-bit RISC-V instruction,
//   sign-extends it to XLEN, flags unsupported formats and registers the
//   result behind a valid/ready handshake. A main register (M) drives the
//   outputs and a skid register (K) absorbs one extra transaction so the
//   stage sustains one transfer per cycle under back-pressure.
// Parameters
//   XLEN        output immediate width, 32 or 64
//   AUTO_DECODE 1: format from opcode, 0: format from bus.imm_sel
//   TAG_W       side-band tag width (e.g. the PC)
// Ports
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  imm_gen_stage_if.slave: in_valid/in_ready/instr/imm_sel/in_tag in,
//        out_valid/out_ready/imm/illegal/out_tag out
module imm_gen_stage #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_BAD = 3'd5
  } fmt_t;

  state_t           state;
  state_t           next_state;
  fmt_t             fmt;

  logic [XLEN-1:0]  new_imm;
  logic             new_ill;

  logic [XLEN-1:0]  m_imm;
  logic             m_ill;
  logic [TAG_W-1:0] m_tag;
  logic [XLEN-1:0]  k_imm;
  logic             k_ill;
  logic [TAG_W-1:0] k_tag;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             acc;
  logic             pop;
  logic             load_m_new;
  logic             load_m_from_k;
  logic             load_k_new;

  // Ready depends only on the state register, so no combinational path
  // exists from in_valid or out_ready back to in_ready.
  assign in_ready_int  = (state != FULL);
  assign out_valid_int = (state != EMPTY);
  assign acc           = bus.in_valid & in_ready_int;
  assign pop           = out_valid_int & bus.out_ready;

  // Format selection: either from the opcode or from the explicit selector.
  always_comb begin : decode_fmt
    fmt = FMT_BAD;
    if (AUTO_DECODE != 0) begin
      case (bus.instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
        7'b0100011:                                     fmt = FMT_S;
        7'b1100011:                                     fmt = FMT_B;
        7'b1101111:                                     fmt = FMT_J;
        7'b0110111, 7'b0010111:                         fmt = FMT_U;
        default:                                        fmt = FMT_BAD;
      endcase
    end else begin
      case (bus.imm_sel)
        3'b000:  fmt = FMT_I;
        3'b001:  fmt = FMT_S;
        3'b010:  fmt = FMT_B;
        3'b011:  fmt = FMT_J;
        3'b100:  fmt = FMT_U;
        default: fmt = FMT_BAD;
      endcase
    end
  end

  // Start from a word full of sign bits and overwrite the low field; this
  // gives sign extension to any XLEN without zero-width replications.
  always_comb begin : build_imm
    new_imm = {XLEN{bus.instr[31]}};
    new_ill = 1'b0;
    case (fmt)
      FMT_I: new_imm[11:0] = bus.instr[31:20];
      FMT_S: new_imm[11:0] = {bus.instr[31:25], bus.instr[11:7]};
      FMT_B: new_imm[12:0] = {bus.instr[31], bus.instr[7], bus.instr[30:25],
                              bus.instr[11:8], 1'b0};
      FMT_J: new_imm[20:0] = {bus.instr[31], bus.instr[19:12], bus.instr[20],
                              bus.instr[30:21], 1'b0};
      FMT_U: new_imm[31:0] = {bus.instr[31:12], 12'h000};
      default: begin
        new_imm = '1;
        new_ill = 1'b1;
      end
    endcase
  end

  // Skid-buffer control. In FULL the stage refuses input, so a pop there
  // only moves K into M.
  always_comb begin : next_state_logic
    next_state    = state;
    load_m_new    = 1'b0;
    load_m_from_k = 1'b0;
    load_k_new    = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_m_new = 1'b1;
          next_state = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          load_m_new = 1'b1;
        end else if (acc) begin
          load_k_new = 1'b1;
          next_state = FULL;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_m_from_k = 1'b1;
          next_state    = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Reset discards everything held, including a transaction offered
  // during the reset cycle.
  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      state <= EMPTY;
      m_imm <= '0;
      m_ill <= 1'b0;
      m_tag <= '0;
      k_imm <= '0;
      k_ill <= 1'b0;
      k_tag <= '0;
    end else begin
      state <= next_state;
      if (load_m_new) begin
        m_imm <= new_imm;
        m_ill <= new_ill;
        m_tag <= bus.in_tag;
      end else if (load_m_from_k) begin
        m_imm <= k_imm;
        m_ill <= k_ill;
        m_tag <= k_tag;
      end
      if (load_k_new) begin
        k_imm <= new_imm;
        k_ill <= new_ill;
        k_tag <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.imm       = m_imm;
  assign bus.illegal   = m_ill;
  assign bus.out_tag   = m_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
//   Drives three stage instances in lockstep with the same handshake
//   stimulus: XLEN=32 auto-decode, XLEN=64 auto-decode, and XLEN=32 with
//   the format taken from imm_sel. Expected results come from a
//   reference model built on signed arithmetic; they are queued when an
//   instruction is accepted and popped by an independent monitor.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  immSel = '0;
  logic [31:0] inTag = '0;
  logic        randReady = 1'b0;
  logic        randBit = 1'b0;
  logic        forcedReady = 1'b0;
  logic        outReady;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [31:0] tag;
    logic [63:0] immAuto;
    logic        illAuto;
    logic [63:0] immMan;
    logic        illMan;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();
  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) busMan ();

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32));
  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64));
  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(32)) dutMan (
    .clk(clk), .rst(rst), .bus(busMan));

  assign outReady = randReady ? randBit : forcedReady;

  assign bus32.in_valid  = inValid;
  assign bus32.instr     = instr;
  assign bus32.imm_sel   = immSel;
  assign bus32.in_tag    = inTag;
  assign bus32.out_ready = outReady;
  assign bus64.in_valid  = inValid;
  assign bus64.instr     = instr;
  assign bus64.imm_sel   = immSel;
  assign bus64.in_tag    = inTag;
  assign bus64.out_ready = outReady;
  assign busMan.in_valid  = inValid;
  assign busMan.instr     = instr;
  assign busMan.imm_sel   = immSel;
  assign busMan.in_tag    = inTag;
  assign busMan.out_ready = outReady;

  // Random consumer back-pressure, about 70% ready.
  always @(posedge clk) begin
    #1;
    randBit = ($urandom_range(0, 99) < 70);
  end

  // Reference model: format number 0..4 for I/S/B/J/U, -1 for illegal.
  function automatic int fmtFromOpcode(logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: return 0;
      7'h23:                      return 1;
      7'h63:                      return 2;
      7'h6F:                      return 3;
      7'h37, 7'h17:               return 4;
      default:                    return -1;
    endcase
  endfunction

  function automatic logic [63:0] refImm(logic [31:0] i, int fmt);
    longint s;
    longint r;
    s = longint'($signed(i));
    case (fmt)
      0: r = s >>> 20;
      1: r = (s >>> 25) * 32 + longint'(i[11:7]);
      2: r = (s >>> 31) * 4096 + longint'(i[7]) * 2048
             + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      3: r = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
             + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      4: r = (s >>> 12) * 4096;
      default: r = -1;
    endcase
    return r;
  endfunction

  function automatic exp_t makeExp(logic [31:0] ins, logic [2:0] sel, logic [31:0] tag);
    exp_t e;
    int fa;
    int fm;
    fa = fmtFromOpcode(ins[6:0]);
    fm = (sel <= 3'd4) ? int'(sel) : -1;
    e.tag     = tag;
    e.immAuto = refImm(ins, fa);
    e.illAuto = (fa < 0);
    e.immMan  = refImm(ins, fm);
    e.illMan  = (fm < 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue mirrors what the stage should be holding, so it
  // also predicts out_valid/in_ready. Outputs are compared every cycle
  // they are valid, which also catches changes while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid32", bus32.out_valid, expQ.size() != 0);
      checkOutput("out_valid64", bus64.out_valid, expQ.size() != 0);
      checkOutput("out_validMan", busMan.out_valid, expQ.size() != 0);
      checkOutput("in_ready32", bus32.in_ready, expQ.size() < 2);
      if (expQ.size() != 0 && bus32.out_valid) begin
        checkOutput("imm32", bus32.imm, expQ[0].immAuto[31:0]);
        checkOutput("ill32", bus32.illegal, expQ[0].illAuto);
        checkOutput("tag32", bus32.out_tag, expQ[0].tag);
        checkOutput("imm64", bus64.imm, expQ[0].immAuto);
        checkOutput("ill64", bus64.illegal, expQ[0].illAuto);
        checkOutput("tag64", bus64.out_tag, expQ[0].tag);
        checkOutput("immMan", busMan.imm, expQ[0].immMan[31:0]);
        checkOutput("illMan", busMan.illegal, expQ[0].illMan);
        checkOutput("tagMan", busMan.out_tag, expQ[0].tag);
        if (outReady) void'(expQ.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one instruction until accepted; called just after a rising edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [2:0] sel,
                               input logic [31:0] tag, output int waits);
    bit accepted;
    accepted = 1'b0;
    waits = 0;
    inValid = 1'b1;
    instr   = ins;
    immSel  = sel;
    inTag   = tag;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      accepted = bus32.in_ready && !rst;
      @(posedge clk);
      if (accepted) expQ.push_back(makeExp(ins, sel, tag));
      #1;
      if (!accepted) waits++;
    end
    inValid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && expQ.size() != 0; c++) idle(1);
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("rst_in_ready", bus32.in_ready, 1);
    checkOutput("rst_imm32", bus32.imm, 0);
    checkOutput("rst_imm64", bus64.imm, 0);
    checkOutput("rst_ill", bus32.illegal, 0);
    checkOutput("rst_tag", bus32.out_tag, 0);
    checkOutput("rst_tagMan", busMan.out_tag, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [6:0] ops [9];
    logic [31:0] ins;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

    // Reset with an instruction offered the whole time; it must vanish.
    rst = 1'b1;
    inValid = 1'b1;
    instr = 32'hFFF00093;
    inTag = 32'hBAD0_0001;
    idle(3);
    rst = 1'b0;
    inValid = 1'b0;
    checkResetState();

    // addi -1, then sw/beq/lui back to back with a free consumer.
    $display("[TB] directed formats");
    forcedReady = 1'b1;
    applyStimulus(32'hFFF00093, 3'b000, 32'd10, w);
    applyStimulus(32'h0020A423, 3'b001, 32'd11, w);
    checkOutput("b2b_wait1", w, 0);
    applyStimulus(32'hFE000EE3, 3'b010, 32'd12, w);
    checkOutput("b2b_wait2", w, 0);
    applyStimulus(32'h123452B7, 3'b100, 32'd13, w);
    checkOutput("b2b_wait3", w, 0);
    applyStimulus(32'h0000007F, 3'b101, 32'd14, w);
    applyStimulus(32'h0000006F, 3'b111, 32'd15, w);
    drain();

    // Back-pressure: two entries fill M and K, the third must wait.
    $display("[TB] back-pressure");
    forcedReady = 1'b0;
    applyStimulus(32'h00100093, 3'b000, 32'd1, w);
    applyStimulus(32'h00200093, 3'b000, 32'd2, w);
    checkOutput("bp_wait2", w, 0);
    inValid = 1'b1;
    instr = 32'h00300093;
    inTag = 32'd3;
    @(negedge clk);
    checkOutput("bp_in_ready_full", bus32.in_ready, 0);
    checkOutput("bp_head_tag", bus32.out_tag, 1);
    @(posedge clk);
    #1;
    forcedReady = 1'b1;
    applyStimulus(32'h00300093, 3'b000, 32'd3, w);
    checkOutput("bp_third_wait", w, 1);
    drain();

    // Reset while FULL: held tags must never reappear.
    $display("[TB] reset while full");
    forcedReady = 1'b0;
    applyStimulus(32'h00500093, 3'b000, 32'd50, w);
    applyStimulus(32'h00600093, 3'b000, 32'd51, w);
    rst = 1'b1;
    inValid = 1'b1;
    inTag = 32'd52;
    @(posedge clk);
    #1;
    expQ.delete();
    rst = 1'b0;
    inValid = 1'b0;
    checkResetState();
    forcedReady = 1'b1;
    applyStimulus(32'h00700093, 3'b000, 32'd60, w);
    drain();

    // Randomised traffic with random gaps and back-pressure.
    $display("[TB] random traffic");
    randReady = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 99) < 85) ins[6:0] = ops[$urandom_range(0, 8)];
      applyStimulus(ins, 3'($urandom_range(0, 7)), 32'd1000 + i, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    randReady = 1'b0;
    forcedReady = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
